// File: rtl/seq_mul_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_mul_hs
//  Function : Sequential shift-and-add multiplier with valid/ready handshake
//             on both operand and product sides. One multiplier bit is
//             processed per CALC cycle, giving an AW+BW-bit exact product.
//  Config   : `define SEQ_MUL_SIGNED_EN enables two's-complement mode,
//             selected per operation by in_signed. Without it the block is
//             unsigned-only and in_signed is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mul_hs #(
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_a,
    input  logic [BW-1:0]    in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW+BW-1:0] out_prod,
    output logic             busy
);

    localparam int              CW        = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(BW - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] mcand_q;
    logic [AW-1:0] acc_q;
    logic [BW-1:0] mplr_q;
    logic [AW:0]   sum_d;
    logic          last_iter;
    logic          accept;
    logic          sgn_q;

    assign last_iter = (cnt_q == LAST_ITER);
    assign accept    = in_valid && (state_q == S_IDLE);

    // The product lives in {acc, multiplier} as the multiplier shifts out,
    // so the output is simply that concatenation (held unchanged in IDLE).
    assign out_prod  = {acc_q, mplr_q};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

`ifdef SEQ_MUL_SIGNED_EN
    // Partial-product adder: sign-extended in signed mode; the multiplier's
    // sign bit carries negative weight, so the last step subtracts.
    always_comb begin
        logic [AW:0] acc_ext;
        logic [AW:0] mc_ext;
        acc_ext = sgn_q ? {acc_q[AW-1], acc_q}     : {1'b0, acc_q};
        mc_ext  = sgn_q ? {mcand_q[AW-1], mcand_q} : {1'b0, mcand_q};
        sum_d   = acc_ext;
        if (mplr_q[0]) begin
            if (sgn_q && last_iter) begin
                sum_d = acc_ext - mc_ext;
            end else begin
                sum_d = acc_ext + mc_ext;
            end
        end
    end
`else
    // Partial-product adder: unsigned, carry out lands in the top bit
    always_comb begin
        sum_d = {1'b0, acc_q};
        if (mplr_q[0]) begin
            sum_d = {1'b0, acc_q} + {1'b0, mcand_q};
        end
    end

    logic unused_signed;
    assign unused_signed = in_signed;
`endif

    // Operand capture and one shift-add iteration per CALC cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
        end else if (accept) begin
            mcand_q <= in_a;
            mplr_q  <= in_b;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sgn_q   <= in_signed;
`else
            sgn_q   <= 1'b0;
`endif
        end else if (state_q == S_CALC) begin
            // Shift {carry, acc, multiplier} right; in signed mode sum_d's
            // top bit is already the correct arithmetic sign.
            acc_q   <= sum_d[AW:1];
            mplr_q  <= {sum_d[0], mplr_q[BW-1:1]};
            cnt_q   <= last_iter ? '0 : cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_hs.sv
`timescale 1ns/1ps
`default_nettype none
module tb_seq_mul_hs;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = AW + BW;
`ifdef SEQ_MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          in_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_prod;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mul_hs #(.AW(AW), .BW(BW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer multiplication of the operands
    function automatic logic [PW-1:0] model(input logic [AW-1:0] a,
                                            input logic [BW-1:0] b,
                                            input logic s);
        int sa;
        int sb;
        int p;
        sa = int'(a);
        sb = int'(b);
        if (s && SIGNED_EN) begin
            sa = $signed(a);
            sb = $signed(b);
        end
        p = sa * sb;
        return p[PW-1:0];
    endfunction

    // Drive one operation from IDLE (called #1 after a rising edge) and
    // check latency, hold behaviour and final return to IDLE.
    task automatic run_op(input string nm, input logic [AW-1:0] a,
                          input logic [BW-1:0] b, input logic s,
                          input logic [PW-1:0] exp, input int hold,
                          input bit pulse);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_in_ready: got %b want 1", nm, in_ready);
        end
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = AW'($urandom); in_b = BW'($urandom); in_signed = 1'($urandom);
        n_tests++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s calc_status: got busy/rdy/vld=%b want 100", nm,
                     {busy, in_ready, out_valid});
        end
        for (int k = 1; k <= BW; k++) begin
            if (pulse && k == 2) begin
                in_a = 8'h03; in_b = 8'h04; in_valid = 1'b1;
            end
            if (pulse && k == 5) in_valid = 1'b0;
            @(posedge clk); #1;
            if (k < BW) begin
                n_tests++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_valid k=%0d: got vld=%b rdy=%b want 0 0",
                             nm, k, out_valid, in_ready);
                end
            end
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_prod !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: got vld=%b prod=%h rdy=%b busy=%b want 1 %h 0 1",
                     nm, out_valid, out_prod, in_ready, busy, exp);
        end
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_prod !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold h=%0d: got vld=%b prod=%h rdy=%b want 1 %h 0",
                         nm, h, out_valid, out_prod, in_ready, exp);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_to_idle: got vld=%b rdy=%b busy=%b want 0 1 0",
                     nm, out_valid, in_ready, busy);
        end
        if (pulse) begin
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                n_tests++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s extra_valid j=%0d: got vld=%b busy=%b want 0 0",
                             nm, j, out_valid, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, busy, in_ready} !== 3'b001 || out_prod !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got vld/busy/rdy=%b prod=%h want 001 0000",
                     {out_valid, busy, in_ready}, out_prod);
        end
        rstn = 1'b1;
        // Accepts on the very first edge after release
        run_op("first_after_reset", 8'h21, 8'h03, 1'b0, 16'h0063, 0, 1'b0);
    endtask

    task automatic test_unsigned_max();
        run_op("u_ff_x_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0);
    endtask

    task automatic test_signed_mode();
        if (SIGNED_EN) begin
            run_op("s_80_x_80", 8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0);
            run_op("s_ff_x_7f", 8'hFF, 8'h7F, 1'b1, 16'hFF81, 1, 1'b0);
            run_op("s_05_x_fd", 8'h05, 8'hFD, 1'b1, 16'hFFF1, 0, 1'b0);
        end else begin
            run_op("nosigned_ff_x_ff", 8'hFF, 8'hFF, 1'b1, 16'hFE01, 0, 1'b0);
        end
    endtask

    task automatic test_hold();
        run_op("hold5", 8'h9A, 8'h3C, 1'b0, 16'h2418, 5, 1'b0);
    endtask

    task automatic test_ignore_during_calc();
        run_op("ignore_calc", 8'h11, 8'h0F, 1'b0, 16'h00FF, 0, 1'b1);
    endtask

    task automatic test_reset_mid_calc();
        in_a = 8'h37; in_b = 8'h55; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, busy, in_ready} !== 3'b001 || out_prod !== '0) begin
            n_fail++;
            $display("FAIL midcalc_reset: got vld/busy/rdy=%b prod=%h want 001 0000",
                     {out_valid, busy, in_ready}, out_prod);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        run_op("after_reset_0c_x_0a", 8'h0C, 8'h0A, 1'b0, 16'h0078, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic          s;
        for (int i = 0; i < 20; i++) begin
            a = AW'($urandom);
            b = BW'($urandom);
            s = 1'($urandom);
            run_op("random", a, b, s, model(a, b, s), int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int            seen[$];
        logic [PW-1:0] exp;
        exp = model(8'hC3, 8'h5A, 1'b0);
        in_a = 8'hC3; in_b = 8'h5A; in_signed = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 3 * (BW + 2) + 2; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                seen.push_back(c);
                n_tests++;
                if (out_prod !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_prod c=%0d: got %h want %h", c, out_prod, exp);
                end
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (seen.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d products want 3", seen.size());
        end else begin
            n_tests++;
            if (seen[0] != BW + 1 || seen[1] - seen[0] != BW + 2 || seen[2] - seen[1] != BW + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d,%0d,%0d want %0d,%0d,%0d",
                         seen[0], seen[1], seen[2], BW + 1, 2 * BW + 3, 3 * BW + 5);
            end
        end
        repeat (BW + 3) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_mode();
        test_hold();
        test_ignore_during_calc();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mul_hs.md
SEQ_MUL_HS -- requirements
Module: seq_mul_hs

Interface
REQ-001 SHALL provide parameter AW, default 8, multiplicand (in_a) width, legal range 2..32.
REQ-002 SHALL provide parameter BW, default 8, multiplier (in_b) width and compute-cycle count, legal range 2..32.
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port in_valid  input  1  operand request.
REQ-006 SHALL provide port in_ready  output  1  block can accept operands.
REQ-007 SHALL provide port in_a  input  AW  multiplicand.
REQ-008 SHALL provide port in_b  input  BW  multiplier.
REQ-009 SHALL provide port in_signed  input  1  treat operands as two's complement; sampled with operands.
REQ-010 SHALL provide port out_valid  output  1  product available.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts product.
REQ-012 SHALL provide port out_prod  output  AW+BW  product.
REQ-013 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept operands on an edge where in_valid && in_ready: latch in_a, in_b, in_signed; clear the accumulator; clear the iteration counter; IDLE->CALC.
REQ-016 SHALL perform one iteration per CALC cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half in an AW+1-bit adder; shift {carry, acc, multiplier} right by 1.
REQ-017 SHALL, in signed mode, sign-extend the multiplicand into the adder, use an arithmetic shift, and on the final iteration (counter==BW-1) subtract the multiplicand instead of adding it.
REQ-018 SHALL leave CALC after exactly BW iterations and enter DONE with out_valid=1; operands accepted at edge N give out_valid high after edge N+BW.
REQ-019 SHALL hold out_prod and out_valid stable in DONE until out_valid && out_ready; DONE->IDLE on that edge, with out_valid=0 from then on.
REQ-020 SHALL ignore in_valid while in CALC or DONE; operands are not queued.
REQ-021 SHALL yield a throughput of one product per BW+2 cycles when out_ready is held high.
REQ-022 SHALL present the exact full-width product; no overflow is possible (AW+BW bits).
REQ-023 SHALL keep out_prod at its last value in IDLE; its value is defined only while out_valid=1.

Reset
REQ-024 SHALL, on rstn low at any time including mid-CALC or in DONE, go to IDLE with out_valid=0, busy=0, in_ready=1, out_prod=0, counter=0, and discard any operation in flight.
REQ-025 SHALL be able to accept operands on the first rising edge after rstn is released.

Configuration
REQ-026 SHALL, with SEQ_MUL_SIGNED_EN defined, support signed mode per REQ-017 under control of in_signed.
REQ-027 SHALL, without SEQ_MUL_SIGNED_EN, ignore in_signed, compute unsigned only, and omit the sign-extension and subtract logic.

Verification (AW=BW=8)
REQ-028 SHALL cover: unsigned 0xFF*0xFF, out_ready=1 -> out_prod=0xFE01, out_valid high 8 cycles after acceptance, for 1 cycle.
REQ-029 SHALL cover, with macro defined: signed 0x80*0x80 -> 0x4000; signed 0xFF*0x7F -> 0xFF81; signed 0x05*0xFD -> 0xFFF1.
REQ-030 SHALL cover: out_ready low for 5 cycles in DONE -> out_prod and out_valid held, in_ready=0, then return to IDLE on the accept edge.
REQ-031 SHALL cover: in_valid with 0x03*0x04 pulsed during CALC -> ignored; the current product is unchanged and no extra out_valid appears.
REQ-032 SHALL cover: rstn asserted at iteration 4 -> immediate IDLE with outputs per REQ-024; the next operation 0x0C*0x0A gives 0x0078.
REQ-033 SHALL cover, with macro undefined: in_signed=1 with 0xFF*0xFF -> 0xFE01.
